// File: rtl/pe_result_collector_pkg.sv
// rtl/pe_result_collector_pkg.sv - shared widths, state encoding and result word layout
package pe_result_collector_pkg;

  localparam int dwidth_float = 32;

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_SEND = 1'b1
  } collector_state_e;

  // Buffered entry: end-of-packet flag travels alongside the data word
  typedef struct packed {
    logic                    last;
    logic [dwidth_float-1:0] data;
  } result_word_t;

endpackage

// File: rtl/pe_result_collector_if.sv
// rtl/pe_result_collector_if.sv - PE result ingress and AXI-Stream egress bundle
interface pe_result_collector_if
  import pe_result_collector_pkg::*;
#(
  parameter int DW = dwidth_float
);

  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  // master: PE plus downstream sink; slave: the collector itself
  modport master (
    output s_data, s_valid, s_last, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  s_data, s_valid, s_last, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/pe_result_collector_sync_fifo.sv
// rtl/pe_result_collector_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and exact count
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves on the same edge
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - buffers PE results, re-emits as AXI-Stream, raises issue credit
module pe_result_collector
  import pe_result_collector_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int LATENCY   = 16,
  parameter int STORE_FWD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_result_collector_if.slave    bus,
  output logic                    o_issue_ok,
  output logic                    o_overflow,
  output logic [$clog2(DEPTH):0]  o_fill,
  output logic [15:0]             o_pkt_done_cnt
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] ISSUE_MAX = (AW+1)'(DEPTH - LATENCY - 1);
  localparam logic [0:0]  ST_WAIT   = S_WAIT;
  localparam logic [0:0]  ST_SEND   = S_SEND;

  result_word_t w_wr_word;
  result_word_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic         w_tvalid;
  logic         w_pop;
  logic         w_accept;
  logic         w_push_last;
  logic         w_pop_last;
  logic         w_start;

  logic [0:0]   r_state;
  logic [AW:0]  r_pkts_buffered;
  logic         r_overflow;
  logic         r_issue_ok;
  logic [15:0]  r_pkt_done_cnt;

  assign w_wr_word = {bus.s_last, bus.s_data};

  sync_fifo #(
    .WIDTH ($bits(result_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.s_valid),
    .i_wdata (w_wr_word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Outputs come straight from the registered head, so they hold until popped
  assign w_tvalid           = (r_state == ST_SEND) && !w_empty;
  assign w_pop              = w_tvalid && bus.m_axis_tready;
  assign bus.m_axis_tvalid  = w_tvalid;
  assign bus.m_axis_tdata   = w_tvalid ? w_head.data : '0;
  assign bus.m_axis_tlast   = w_tvalid && w_head.last;

  assign w_accept    = bus.s_valid && (!w_full || w_pop);
  assign w_push_last = w_accept && bus.s_last;
  assign w_pop_last  = w_pop && w_head.last;

  // A full FIFO with no complete packet forces cut-through so oversize packets drain
  assign w_start = !w_empty &&
                   ((STORE_FWD == 0) || (r_pkts_buffered != '0) || w_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_WAIT;
      r_pkt_done_cnt <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_start) r_state <= ST_SEND;
        end
        default: begin
          if (w_pop_last) begin
            r_state        <= ST_WAIT;
            r_pkt_done_cnt <= r_pkt_done_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkts_buffered <= '0;
    end else if (w_push_last && !w_pop_last) begin
      r_pkts_buffered <= r_pkts_buffered + (AW+1)'(1);
    end else if (!w_push_last && w_pop_last) begin
      r_pkts_buffered <= r_pkts_buffered - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_issue_ok <= 1'b1;
    end else begin
      if (bus.s_valid && !w_accept) r_overflow <= 1'b1;
      r_issue_ok <= (w_count <= ISSUE_MAX);
    end
  end

  assign o_issue_ok     = r_issue_ok;
  assign o_overflow     = r_overflow;
  assign o_fill         = w_count;
  assign o_pkt_done_cnt = r_pkt_done_cnt;

endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - directed self-checking bench for pe_result_collector
module tb_pe_result_collector;
  import pe_result_collector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_result_collector_if bus_ct ();
  pe_result_collector_if bus_sf ();

  logic        ct_issue_ok, ct_overflow, sf_issue_ok, sf_overflow;
  logic [5:0]  ct_fill, sf_fill;
  logic [15:0] ct_pkt, sf_pkt;

  pe_result_collector #(.DEPTH(32), .LATENCY(16), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst(rst), .bus(bus_ct),
    .o_issue_ok(ct_issue_ok), .o_overflow(ct_overflow),
    .o_fill(ct_fill), .o_pkt_done_cnt(ct_pkt)
  );

  pe_result_collector #(.DEPTH(32), .LATENCY(16), .STORE_FWD(1)) u_sf (
    .clk(clk), .rst(rst), .bus(bus_sf),
    .o_issue_ok(sf_issue_ok), .o_overflow(sf_overflow),
    .o_fill(sf_fill), .o_pkt_done_cnt(sf_pkt)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] fwords [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_queue(input string tag);
    check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val(tag, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // Drive one cycle (sel 0 = cut-through DUT, 1 = store-forward DUT) and log the handshake
  task automatic cyc(input bit sel, input bit v, input logic [31:0] d, input bit l, input bit rdy);
    bus_ct.s_valid       = (sel == 1'b0) && v;
    bus_ct.s_data        = d;
    bus_ct.s_last        = l;
    bus_ct.m_axis_tready = (sel == 1'b0) && rdy;
    bus_sf.s_valid       = (sel == 1'b1) && v;
    bus_sf.s_data        = d;
    bus_sf.s_last        = l;
    bus_sf.m_axis_tready = (sel == 1'b1) && rdy;
    if (!rst) begin
      if (sel == 1'b0 && rdy && bus_ct.m_axis_tvalid)
        got_q.push_back({bus_ct.m_axis_tlast, bus_ct.m_axis_tdata});
      if (sel == 1'b1 && rdy && bus_sf.m_axis_tvalid)
        got_q.push_back({bus_sf.m_axis_tlast, bus_sf.m_axis_tdata});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset held two cycles with s_valid asserted
    rst = 1'b1;
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check_val("rst_tvalid", bus_ct.m_axis_tvalid, 0);
    check_val("rst_tlast", bus_ct.m_axis_tlast, 0);
    check_val("rst_tdata", bus_ct.m_axis_tdata, 0);
    check_val("rst_fill", ct_fill, 0);
    check_val("rst_overflow", ct_overflow, 0);
    check_val("rst_pkt", ct_pkt, 0);
    check_val("rst_issue_ok", ct_issue_ok, 1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_val("rst_nothing_written", ct_fill, 0);
    check_val("rst_tvalid_after", bus_ct.m_axis_tvalid, 0);

    // Cut-through, 8 floats, tready held high
    got_q.delete();
    cyc(1'b0, 1'b1, fwords[0], 1'b0, 1'b1);
    check_val("ct_tvalid_edgeN", bus_ct.m_axis_tvalid, 0);
    cyc(1'b0, 1'b1, fwords[1], 1'b0, 1'b1);
    check_val("ct_tvalid_edgeN1", bus_ct.m_axis_tvalid, 1);
    for (int i = 2; i < 8; i++) cyc(1'b0, 1'b1, fwords[i], i == 7, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, fwords[i]});
    check_queue("ct_words");
    check_val("ct_pkt_done", ct_pkt, 1);

    // Backpressure: credit threshold, full, overflow, ordered drain
    do_reset();
    for (int i = 1; i <= 33; i++) begin
      cyc(1'b0, 1'b1, 32'hA000_0000 + i, i == 32, 1'b0);
      if (i <= 32) exp_q.push_back({i == 32, 32'hA000_0000 + i});
      if (i == 15) begin
        check_val("bp_issue_ok_15", ct_issue_ok, 1);
        check_val("bp_fill_15", ct_fill, 15);
      end
      if (i == 16) check_val("bp_issue_ok_16", ct_issue_ok, 1);
      if (i == 17) check_val("bp_issue_ok_next", ct_issue_ok, 0);
      if (i == 32) begin
        check_val("bp_fill_32", ct_fill, 32);
        check_val("bp_no_overflow", ct_overflow, 0);
      end
    end
    check_val("bp_overflow", ct_overflow, 1);
    check_val("bp_fill_after_drop", ct_fill, 32);
    check_val("bp_tvalid_held", bus_ct.m_axis_tvalid, 1);
    for (int i = 0; i < 36; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_queue("bp_drain");
    check_val("bp_fill_empty", ct_fill, 0);
    check_val("bp_pkt_done", ct_pkt, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 32; i++) cyc(1'b0, 1'b1, 32'hB000_0000 + i, 1'b0, 1'b0);
    for (int i = 33; i <= 40; i++) begin
      cyc(1'b0, 1'b1, 32'hB000_0000 + i, i == 40, 1'b1);
      check_val("pp_fill", ct_fill, 32);
    end
    check_val("pp_overflow", ct_overflow, 0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 40; i++) exp_q.push_back({i == 40, 32'hB000_0000 + i});
    check_queue("pp_order");
    check_val("pp_pkt_done", ct_pkt, 1);

    // Store-and-forward: no output until tlast is buffered
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) cyc(1'b1, 1'b1, 32'hC000_0001 + i / 2, i == 8, 1'b1);
      else            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      check_val("sf_tvalid_wait", bus_sf.m_axis_tvalid, 0);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_val("sf_b2b_tvalid", bus_sf.m_axis_tvalid, 1);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    check_val("sf_tvalid_done", bus_sf.m_axis_tvalid, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 32'hC000_0001 + i});
    check_queue("sf_words");
    check_val("sf_pkt_done", sf_pkt, 1);

    // Store-and-forward, 40-word packet without tlast: forced cut-through at full
    got_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b1, 32'hD000_0000 + i, 1'b0, 1'b1);
      if (i != 33) exp_q.push_back({1'b0, 32'hD000_0000 + i});
      if (i == 32) begin
        check_val("sf_big_fill_32", sf_fill, 32);
        check_val("sf_big_tvalid_hold", bus_sf.m_axis_tvalid, 0);
      end
      if (i == 33) begin
        check_val("sf_big_forced", bus_sf.m_axis_tvalid, 1);
        check_val("sf_big_overflow", sf_overflow, 1);
      end
    end
    for (int i = 0; i < 45; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_queue("sf_big_words");
    check_val("sf_big_drained", sf_fill, 0);

    // Reset mid-packet, then a clean 2-word packet
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b1, 32'hE000_0000 + i, i == 6, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) exp_q.push_back({1'b0, 32'hE000_0000 + i});
    check_queue("mr_partial");
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    check_val("mr_tvalid", bus_ct.m_axis_tvalid, 0);
    check_val("mr_fill", ct_fill, 0);
    got_q.delete();
    exp_q.delete();
    cyc(1'b0, 1'b1, 32'hF000_0001, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'hF000_0002, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 32'hF000_0001});
    exp_q.push_back({1'b1, 32'hF000_0002});
    check_queue("mr_new_pkt");
    check_val("mr_pkt_done", ct_pkt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
